// File: rtl/digit_lock_fsm_pkg.sv
// Shared types and helpers for the keypad code lock: state encoding, digit width,
// code nibble selection and timer sizing.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        OPEN,
        LOCKOUT
    } lock_state_t;

    localparam int DIGIT_W    = 4;
    localparam int MAX_CODE_W = 32;

    // Digit 0 sits in the most-significant nibble of an n_digits-wide code.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [MAX_CODE_W-1:0] code,
                                                    input int idx,
                                                    input int n_digits);
        logic [MAX_CODE_W-1:0] shifted;
        shifted = code >> (DIGIT_W * (n_digits - 1 - idx));
        return shifted[DIGIT_W-1:0];
    endfunction

    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/digit_lock_fsm_if.sv
// Keypad, comparator and status signals of the code lock, bundled for the lock
// (slave) and the keypad/comparator side (master).
interface digit_lock_fsm_if #(
    parameter int N_DIGITS = 4,
    parameter int MAX_FAIL = 3
);
    logic [lock_pkg::DIGIT_W-1:0]            digit_in;
    logic                                    digit_valid;
    logic                                    digit_ready;
    logic                                    clear;
    logic                                    code_load;
    logic [lock_pkg::DIGIT_W*N_DIGITS-1:0]   code_in;
    logic [lock_pkg::DIGIT_W-1:0]            cmp_a;
    logic [lock_pkg::DIGIT_W-1:0]            cmp_b;
    logic                                    cmp_eq;
    logic                                    unlocked;
    logic                                    locked_out;
    logic [$clog2(MAX_FAIL+1)-1:0]           fail_count;
    logic [$clog2(N_DIGITS)-1:0]             digit_idx;

    modport master (
        output digit_in, digit_valid, clear, code_load, code_in, cmp_eq,
        input  digit_ready, cmp_a, cmp_b, unlocked, locked_out, fail_count, digit_idx
    );

    modport slave (
        input  digit_in, digit_valid, clear, code_load, code_in, cmp_eq,
        output digit_ready, cmp_a, cmp_b, unlocked, locked_out, fail_count, digit_idx
    );

endinterface

// File: rtl/digit_lock_fsm_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT windows; done flags zero.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/digit_lock_fsm.sv
// Keypad code lock controller: sequences digits through an external comparator,
// counts failed attempts and times the unlock and lockout windows.
module digit_lock_fsm
    import lock_pkg::*;
#(
    parameter int                        N_DIGITS    = 4,
    parameter int                        MAX_FAIL    = 3,
    parameter int                        OPEN_CYCLES = 8,
    parameter int                        LOCK_CYCLES = 16,
    parameter logic [DIGIT_W*N_DIGITS-1:0] RESET_CODE = 16'h1234
) (
    input  logic             clk,
    input  logic             reset,
    digit_lock_fsm_if.slave  bus
);
    localparam int CODE_W = DIGIT_W * N_DIGITS;
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = timer_w(OPEN_CYCLES, LOCK_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0] OPEN_TV  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_TV  = TMR_W'(LOCK_CYCLES - 1);

    lock_state_t       state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              mismatch, mismatch_next;
    logic [FC_W-1:0]   fail_q, fail_next;
    logic [CODE_W-1:0] code_q;
    logic              timer_load;
    logic [TMR_W-1:0]  timer_val;
    logic              timer_done;
    logic              accept;
    logic              final_mm;

    assign accept   = bus.digit_valid && bus.digit_ready && !bus.clear;
    assign final_mm = mismatch | ~bus.cmp_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        mismatch_next = mismatch;
        fail_next     = fail_q;
        timer_load    = 1'b0;
        timer_val     = OPEN_TV;
        unique case (state)
            IDLE, ENTER: begin
                if (bus.clear) begin
                    state_next    = IDLE;
                    idx_next      = '0;
                    mismatch_next = 1'b0;
                end else if (accept && idx == IDX_LAST) begin
                    idx_next      = '0;
                    mismatch_next = 1'b0;
                    if (!final_mm) begin
                        state_next = OPEN;
                        fail_next  = '0;
                        timer_load = 1'b1;
                        timer_val  = OPEN_TV;
                    end else if (fail_q + 1'b1 != FC_MAX) begin
                        state_next = IDLE;
                        fail_next  = fail_q + 1'b1;
                    end else begin
                        state_next = LOCKOUT;
                        fail_next  = FC_MAX;
                        timer_load = 1'b1;
                        timer_val  = LOCK_TV;
                    end
                end else if (accept) begin
                    state_next    = ENTER;
                    idx_next      = idx + 1'b1;
                    mismatch_next = final_mm;
                end
            end
            OPEN: begin
                if (timer_done) state_next = IDLE;
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_next = IDLE;
                    fail_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.digit_ready = (state == IDLE) || (state == ENTER);
        bus.unlocked    = (state == OPEN);
        bus.locked_out  = (state == LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            mismatch <= 1'b0;
            fail_q   <= '0;
            code_q   <= RESET_CODE;
        end else begin
            idx      <= idx_next;
            mismatch <= mismatch_next;
            fail_q   <= fail_next;
            // Code change is only trusted while the lock is open.
            if (state == OPEN && bus.code_load) code_q <= bus.code_in;
        end
    end

    lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       ((state == OPEN) || (state == LOCKOUT)),
        .done     (timer_done)
    );

    assign bus.cmp_a      = bus.digit_in;
    assign bus.cmp_b      = digit_of(MAX_CODE_W'(code_q), int'(idx), N_DIGITS);
    assign bus.fail_count = fail_q;
    assign bus.digit_idx  = idx;

endmodule

// File: tb/tb_digit_lock_fsm.sv
// Directed bench for digit_lock_fsm with a behavioural 4-bit equality comparator
// closing the cmp_a/cmp_b -> cmp_eq loop.
module tb_digit_lock_fsm;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    digit_lock_fsm_if #(.N_DIGITS(4), .MAX_FAIL(3)) bus ();

    assign bus.cmp_eq = (bus.cmp_a == bus.cmp_b);

    digit_lock_fsm #(
        .N_DIGITS   (4),
        .MAX_FAIL   (3),
        .OPEN_CYCLES(8),
        .LOCK_CYCLES(16),
        .RESET_CODE (16'h1234)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) send(c[15-4*i -: 4]);
    endtask

    // sel=0 checks the OPEN window, sel=1 the LOCKOUT window; n cycles then exit.
    task automatic expect_window(input string tag, input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, sel ? bus.locked_out : bus.unlocked, 1);
            check({tag, "_rdy"}, bus.digit_ready, 0);
            tick();
        end
        check({tag, "_exit_u"}, bus.unlocked, 0);
        check({tag, "_exit_l"}, bus.locked_out, 0);
        check({tag, "_exit_rdy"}, bus.digit_ready, 1);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.digit_in    = '0;
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        bus.code_load   = 1'b0;
        bus.code_in     = '0;
        #12;
        check("rst_unlocked", bus.unlocked, 0);
        check("rst_locked", bus.locked_out, 0);
        check("rst_fail", bus.fail_count, 0);
        check("rst_idx", bus.digit_idx, 0);
        check("rst_ready", bus.digit_ready, 1);
        check("rst_cmp_b", bus.cmp_b, 4'h1);
        reset = 1'b0;
        tick();

        // Correct code opens for exactly 8 cycles.
        enter_code(16'h1234);
        check("open_fail", bus.fail_count, 0);
        expect_window("open1", 1'b0, 8);

        // Three wrong attempts, lockout ignores digits, then entry works.
        enter_code(16'h1235);
        check("f1_count", bus.fail_count, 1);
        check("f1_unl", bus.unlocked, 0);
        enter_code(16'h1235);
        check("f2_count", bus.fail_count, 2);
        check("f2_unl", bus.unlocked, 0);
        enter_code(16'h1235);
        check("lock_fail", bus.fail_count, 3);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                bus.digit_in    = 4'(i + 1);
                bus.digit_valid = 1'b1;
            end else begin
                bus.digit_valid = 1'b0;
            end
            check("lock_win", bus.locked_out, 1);
            check("lock_idx", bus.digit_idx, 0);
            tick();
        end
        bus.digit_valid = 1'b0;
        check("lock_exit", bus.locked_out, 0);
        check("lock_exit_fail", bus.fail_count, 0);
        check("lock_exit_unl", bus.unlocked, 0);
        enter_code(16'h1234);
        expect_window("open2", 1'b0, 8);

        // Clear mid-entry, then clear colliding with a digit strobe.
        send(4'h1);
        send(4'h2);
        check("clr_idx_pre", bus.digit_idx, 2);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_idx", bus.digit_idx, 0);
        check("clr_fail", bus.fail_count, 0);
        enter_code(16'h1234);
        expect_window("open3", 1'b0, 8);
        bus.digit_in    = 4'h1;
        bus.digit_valid = 1'b1;
        bus.clear       = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        check("clrv_idx", bus.digit_idx, 0);
        check("clrv_unl", bus.unlocked, 0);

        // Code reload while open; timer is not disturbed.
        enter_code(16'h1234);
        bus.code_in   = 16'hA5C3;
        bus.code_load = 1'b1;
        expect_window("open_load", 1'b0, 8);
        bus.code_load = 1'b0;
        check("load_cmp_b", bus.cmp_b, 4'hA);
        bus.code_in   = 16'h1111;
        bus.code_load = 1'b1;
        tick();
        bus.code_load = 1'b0;
        check("idle_load_cmp_b", bus.cmp_b, 4'hA);
        enter_code(16'h1234);
        check("old_code_fail", bus.fail_count, 1);
        check("old_code_unl", bus.unlocked, 0);
        enter_code(16'hA5C3);
        check("new_code_fail", bus.fail_count, 0);
        expect_window("open_new", 1'b0, 8);

        // Two failures then success clears the count.
        enter_code(16'h1234);
        enter_code(16'h1234);
        check("ff_count", bus.fail_count, 2);
        enter_code(16'hA5C3);
        check("ff_open_fail", bus.fail_count, 0);
        expect_window("open_ff", 1'b0, 8);

        // Asynchronous reset during digit 3 restores the reset code.
        enter_code(16'h1234);
        check("pre_rst_fail", bus.fail_count, 1);
        send(4'hA);
        send(4'h5);
        bus.digit_in    = 4'hC;
        bus.digit_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_idx", bus.digit_idx, 0);
        check("arst_fail", bus.fail_count, 0);
        check("arst_unl", bus.unlocked, 0);
        check("arst_cmp_b", bus.cmp_b, 4'h1);
        bus.digit_valid = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        enter_code(16'h1234);
        expect_window("open_rst", 1'b0, 8);

        // Wrong first digit: verdict only after all four digits.
        send(4'h9);
        send(4'h2);
        send(4'h3);
        check("late_idx", bus.digit_idx, 3);
        check("late_fail_pre", bus.fail_count, 0);
        check("late_unl_pre", bus.unlocked, 0);
        send(4'h4);
        check("late_fail", bus.fail_count, 1);
        check("late_idx0", bus.digit_idx, 0);
        check("late_unl", bus.unlocked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_lock_fsm.md
Name: digit_lock_fsm

Overview:
- Sequential controller for a keypad code lock, one 4-bit digit per strobe.
- Sits upstream and downstream of the team's 4-bit equality comparator: it drives the comparator's A/B operands and consumes its E output.
- Tracks the digit sequence, counts failed attempts, and generates timed unlock and lockout windows.
- Owns the stored code register and its reload path.

Parameters:
- N_DIGITS, 4, digits per code; allowed range 2..8.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout; must be ≥1.
- OPEN_CYCLES, 8, cycles that unlocked stays high; must be ≥1.
- LOCK_CYCLES, 16, cycles spent in lockout; must be ≥1.
- RESET_CODE, 16'h1234, code loaded at reset; width 4*N_DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- digit_in  in  4  keypad digit.
- digit_valid  in  1  digit strobe; one digit per cycle while high.
- clear  in  1  aborts the entry in progress.
- code_load  in  1  requests a code reload.
- code_in  in  4*N_DIGITS  new code; digit 0 is in the MS nibble.
- cmp_a  out  4  comparator operand A; equals digit_in (combinational).
- cmp_b  out  4  comparator operand B; equals stored digit[idx] (combinational).
- cmp_eq  in  1  comparator E output; combinational A==B.
- digit_ready  out  1  digit accepted this cycle if digit_valid is high.
- unlocked  out  1  high during the OPEN window.
- locked_out  out  1  high during LOCKOUT.
- fail_count  out  $clog2(MAX_FAIL+1)  current consecutive failure count.
- digit_idx  out  $clog2(N_DIGITS)  next digit position expected.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, idx=0, mismatch=0, fail_count=0, timer=0, code_q=RESET_CODE, unlocked=0, locked_out=0.
- States: IDLE, ENTER, OPEN, LOCKOUT. All outputs are registered state decodes except cmp_a, cmp_b and digit_ready.
- digit_ready=1 in IDLE and ENTER; 0 in OPEN and LOCKOUT. digit_valid outside those states is ignored, with no side effects.
- Digit accept = digit_valid && digit_ready && !clear. On accept:
  - mismatch |= ~cmp_eq.
  - idx increments.
  - IDLE moves to ENTER.
- Last digit (accept with idx==N_DIGITS-1): next cycle idx=0 and mismatch=0, then:
  - If final mismatch is 0 (prior mismatch | ~cmp_eq): go to OPEN, fail_count=0, timer=OPEN_CYCLES-1. unlocked rises the cycle after the last digit (latency 1) and stays high exactly OPEN_CYCLES cycles, then IDLE.
  - On mismatch with fail_count+1 < MAX_FAIL: fail_count+=1, go to IDLE.
  - On mismatch with fail_count+1 == MAX_FAIL: go to LOCKOUT, fail_count=MAX_FAIL, timer=LOCK_CYCLES-1. locked_out is high exactly LOCK_CYCLES cycles. On exit: go to IDLE, fail_count=0.
- The mismatch verdict is reported only after all N digits; there is no early exit on a wrong digit.
- clear in ENTER or IDLE: idx=0, mismatch=0, go to IDLE. clear does not change fail_count and is not a failure. clear has priority over a simultaneous digit_valid. clear is ignored in OPEN and LOCKOUT.
- code_load is honoured only in OPEN (authenticated change): code_q<=code_in the next edge. The OPEN timer is not altered. code_load in any other state is ignored.
- Timer decrements every cycle in OPEN and LOCKOUT. Exit occurs on the cycle after timer==0. There is no early exit.
- Reset mid-operation returns everything to reset values, including reloading RESET_CODE.

Decomposition:
- Shared package lock_pkg holds:
  - typedef enum logic [1:0] lock_state_t {IDLE, ENTER, OPEN, LOCKOUT}.
  - localparam DIGIT_W=4.
  - function digit_of(code, idx) returning the nibble at digit position idx, MS nibble first.
- One sub-module: lock_timer (loadable down-counter, width $clog2(max(OPEN_CYCLES,LOCK_CYCLES)), outputs done). It serves both the OPEN and LOCKOUT windows.
- The comparator stays external. The bench instantiates the existing 4-bit equality comparator between cmp_a/cmp_b and cmp_eq.

Test Plan:
- Defaults, reset, then digits 1,2,3,4 on consecutive cycles → unlocked=1 the cycle after digit 4, high 8 cycles, fail_count=0, digit_ready=0 throughout.
- Digits 1,2,3,5 three times → fail_count 1 then 2 (unlocked stays 0); third attempt gives locked_out=1 for 16 cycles, then IDLE with fail_count=0. Digits 1,2,3,4 presented during lockout are ignored, and entry works afterwards.
- Digits 1,2, clear, then 1,2,3,4 → clear resets digit_idx to 0, fail_count is unchanged at 0, and the system opens. Also check clear+digit_valid in the same cycle: digit dropped, digit_idx=0.
- During OPEN, code_load with code_in=16'hA5C3 → after the timer expires, 1,2,3,4 fails (fail_count=1) and A,5,C,3 opens. code_load in IDLE is ignored.
- Fail twice, then a correct entry → fail_count returns to 0 on open. Assert reset in the middle of digit 3 → outputs are 0 immediately (asynchronous), and code 1234 is restored.
- Wrong first digit 9 followed by 2,3,4 → no early reject; verdict comes only after digit 4 with fail_count=1.
